// File: rtl/fj_cells_pkg.sv
// Shared constants for the fj gate-array cell library: count direction
// encodings and the legal width range for the parametrised counter cells.
package fj_cells_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam int CNT_WMIN = 2;
    localparam int CNT_WMAX = 32;

endpackage : fj_cells_pkg

// File: rtl/cell_cnt_capture.sv
// Capture register for cell_updown_counter: snapshots the pre-update count on
// a strobe, tracks capture-valid and a sticky overrun until acknowledged.
module cell_cnt_capture
    import fj_cells_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cap_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] cq_o,
    output logic             cv_o,
    output logic             ovr_o
);

    logic [WIDTH-1:0] cq_q, cq_d;
    logic             cv_q, cv_d;
    logic             ovr_q, ovr_d;

    // Next-state: a strobe beats an acknowledge; overrun is a capture onto an unread value.
    always_comb begin
        cq_d  = cq_q;
        cv_d  = cv_q;
        ovr_d = ovr_q;
        if (cap_i) begin
            cq_d = q_i;
            cv_d = 1'b1;
            if (ack_i) begin
                ovr_d = 1'b0;
            end else if (cv_q) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (ack_i) begin
            cv_d  = 1'b0;
            ovr_d = 1'b0;
        end else begin
            cv_d = cv_q;
        end
    end

    // Capture state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cq_q  <= {WIDTH{1'b0}};
            cv_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            cq_q  <= cq_d;
            cv_q  <= cv_d;
            ovr_q <= ovr_d;
        end
    end

    assign cq_o  = cq_q;
    assign cv_o  = cv_q;
    assign ovr_o = ovr_q;

endmodule : cell_cnt_capture

// File: rtl/cell_updown_counter.sv
// Parametrised up/down counter cell with cascade out, registered terminal-count
// pulse and optional divider reload. Capture logic enabled by RDPIANO_CNT_CAPTURE_EN.
module cell_updown_counter
    import fj_cells_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int RELOAD = 0
) (
    input  logic             CK,
    input  logic             nR,
    input  logic [WIDTH-1:0] D,
    input  logic             nL,
    input  logic             nCL,
    input  logic             EN,
    input  logic             CI,
    input  logic             UD,
    input  logic             CAP,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TCP,
    output logic [WIDTH-1:0] CQ,
    output logic             CV,
    output logic             OVR
);

    if ((WIDTH < CNT_WMIN) || (WIDTH > CNT_WMAX)) begin : g_width_check
        $error("cell_updown_counter: WIDTH out of range");
    end

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             tcp_q, tcp_d;
    logic             terminal_s;
    logic             step_s;

    assign terminal_s = (UD == CNT_UP) ? (q_q == ALL_ONES) : (q_q == ALL_ZERO);
    assign step_s     = EN & CI;
    assign CO         = terminal_s & CI;

    // Next-state: load beats clear beats step; only a step off terminal raises TCP.
    always_comb begin
        q_d   = q_q;
        tcp_d = 1'b0;
        if (!nL) begin
            q_d = D;
        end else if (!nCL) begin
            q_d = ALL_ZERO;
        end else if (step_s) begin
            tcp_d = terminal_s;
            if (terminal_s && (RELOAD != 0)) begin
                q_d = D;
            end else if (UD == CNT_UP) begin
                q_d = q_q + ONE;
            end else begin
                q_d = q_q - ONE;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Count and terminal-pulse registers.
    always_ff @(posedge CK or negedge nR) begin
        if (!nR) begin
            q_q   <= ALL_ZERO;
            tcp_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tcp_q <= tcp_d;
        end
    end

    assign Q   = q_q;
    assign TCP = tcp_q;

`ifdef RDPIANO_CNT_CAPTURE_EN
    cell_cnt_capture #(
        .WIDTH (WIDTH)
    ) u_capture (
        .clk_i   (CK),
        .rst_n_i (nR),
        .cap_i   (CAP),
        .ack_i   (ACK),
        .q_i     (q_q),
        .cq_o    (CQ),
        .cv_o    (CV),
        .ovr_o   (OVR)
    );
`else
    logic unused_capture_s;
    assign unused_capture_s = CAP ^ ACK;
    assign CQ  = ALL_ZERO;
    assign CV  = 1'b0;
    assign OVR = 1'b0;
`endif

endmodule : cell_updown_counter

// File: tb/tb_cell_updown_counter.sv
// Directed self-checking bench for cell_updown_counter: wrap, reload divider,
// priority, cascade, capture and asynchronous reset.
module tb_cell_updown_counter;

`ifdef RDPIANO_CNT_CAPTURE_EN
    localparam bit CAP_ON = 1'b1;
`else
    localparam bit CAP_ON = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic CK = 1'b0;
    logic nR = 1'b0;
    always #5 CK = ~CK;

    // Main 8-bit wrapping counter
    logic [7:0] d, q, cq;
    logic       nl = 1'b1, ncl = 1'b1, en = 1'b0, ci = 1'b1, ud = 1'b1, cap = 1'b0, ack = 1'b0;
    logic       co, tcp, cv, ovr;

    // 8-bit reload divider
    logic [7:0] rd, rq, rcq;
    logic       ren = 1'b0, rud = 1'b0;
    logic       rco, rtcp, rcv, rovr;

    // Cascaded pair of 4-bit cells
    logic [3:0] lo_q, hi_q, lo_cq, hi_cq;
    logic       cen = 1'b0;
    logic       lo_co, hi_co, lo_tcp, hi_tcp, lo_cv, hi_cv, lo_ovr, hi_ovr;

    cell_updown_counter #(.WIDTH(8), .RELOAD(0)) dut (
        .CK(CK), .nR(nR), .D(d), .nL(nl), .nCL(ncl), .EN(en), .CI(ci), .UD(ud),
        .CAP(cap), .ACK(ack), .Q(q), .CO(co), .TCP(tcp), .CQ(cq), .CV(cv), .OVR(ovr)
    );

    cell_updown_counter #(.WIDTH(8), .RELOAD(1)) dut_r (
        .CK(CK), .nR(nR), .D(rd), .nL(1'b1), .nCL(1'b1), .EN(ren), .CI(1'b1), .UD(rud),
        .CAP(1'b0), .ACK(1'b0), .Q(rq), .CO(rco), .TCP(rtcp), .CQ(rcq), .CV(rcv), .OVR(rovr)
    );

    cell_updown_counter #(.WIDTH(4), .RELOAD(0)) dut_lo (
        .CK(CK), .nR(nR), .D(4'h0), .nL(1'b1), .nCL(1'b1), .EN(cen), .CI(1'b1), .UD(1'b1),
        .CAP(1'b0), .ACK(1'b0), .Q(lo_q), .CO(lo_co), .TCP(lo_tcp), .CQ(lo_cq), .CV(lo_cv), .OVR(lo_ovr)
    );

    cell_updown_counter #(.WIDTH(4), .RELOAD(0)) dut_hi (
        .CK(CK), .nR(nR), .D(4'h0), .nL(1'b1), .nCL(1'b1), .EN(cen), .CI(lo_co), .UD(1'b1),
        .CAP(1'b0), .ACK(1'b0), .Q(hi_q), .CO(hi_co), .TCP(hi_tcp), .CQ(hi_cq), .CV(hi_cv), .OVR(hi_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    initial begin
        int tcp_hits;
        int co_hits;
        d  = 8'h00;
        rd = 8'h09;

        // Reset state
        #12;
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_tcp", {31'd0, tcp}, 32'd0);
        chk("rst_cq", {24'd0, cq}, 32'd0);
        chk("rst_cv", {31'd0, cv}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);
        chk("rst_co_up", {31'd0, co}, 32'd0);
        ud = 1'b0;
        #1;
        chk("rst_co_down", {31'd0, co}, 32'd1);
        ud = 1'b1;
        @(negedge CK);
        nR = 1'b1;
        tick();

        // Up-count with natural wrap over 260 edges
        en = 1'b1;
        tcp_hits = 0;
        co_hits  = 0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk("up_q", {24'd0, q}, k % 256);
            chk("up_tcp", {31'd0, tcp}, (k == 256) ? 32'd1 : 32'd0);
            chk("up_co", {31'd0, co}, ((k % 256) == 255) ? 32'd1 : 32'd0);
            if (tcp) tcp_hits++;
            if (co) co_hits++;
        end
        chk("up_final_q", {24'd0, q}, 32'd4);
        chk("up_tcp_once", tcp_hits, 32'd1);
        chk("up_co_once", co_hits, 32'd1);
        en = 1'b0;

        // Reload divider counting down from D=9
        ren = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk("div_q", {24'd0, rq}, 32'd9 - ((k - 1) % 10));
            chk("div_tcp", {31'd0, rtcp}, (((k - 1) % 10) == 0) ? 32'd1 : 32'd0);
        end
        ren = 1'b0;
        chk("idle_hold_q", {24'd0, q}, 32'd4);

        // Priority: load beats clear beats step
        nl = 1'b0; ncl = 1'b0; en = 1'b1; d = 8'hA5;
        tick();
        chk("prio_load_q", {24'd0, q}, 32'hA5);
        chk("prio_load_tcp", {31'd0, tcp}, 32'd0);
        nl = 1'b1;
        tick();
        chk("prio_clr_q", {24'd0, q}, 32'd0);
        chk("prio_clr_tcp", {31'd0, tcp}, 32'd0);
        ncl = 1'b1;
        nl = 1'b0; d = 8'hFF;
        tick();
        nl = 1'b0; d = 8'h03;
        tick();
        chk("load_at_term_q", {24'd0, q}, 32'h03);
        chk("load_at_term_tcp", {31'd0, tcp}, 32'd0);
        nl = 1'b1; ci = 1'b0;
        tick();
        chk("ci_low_hold_q", {24'd0, q}, 32'h03);
        chk("ci_low_co", {31'd0, co}, 32'd0);
        ci = 1'b1; ud = 1'b0;
        tick();
        chk("down_step_q", {24'd0, q}, 32'h02);
        ud = 1'b1; en = 1'b0;

        // Cascade of two 4-bit cells
        cen = 1'b1;
        for (int k = 1; k <= 16; k++) tick();
        chk("casc_16", {24'd0, hi_q, lo_q}, 32'h10);
        for (int k = 17; k <= 300; k++) tick();
        chk("casc_300", {24'd0, hi_q, lo_q}, 32'd44);
        cen = 1'b0;

        // Capture sequence
        nl = 1'b0; d = 8'd17;
        tick();
        nl = 1'b1; en = 1'b1; cap = 1'b1;
        tick();
        chk("cap1_q", {24'd0, q}, 32'd18);
        chk("cap1_cq", {24'd0, cq}, CAP_ON ? 32'd17 : 32'd0);
        chk("cap1_cv", {31'd0, cv}, CAP_ON ? 32'd1 : 32'd0);
        chk("cap1_ovr", {31'd0, ovr}, 32'd0);
        cap = 1'b0;
        tick();
        cap = 1'b1;
        tick();
        chk("cap2_cq", {24'd0, cq}, CAP_ON ? 32'd19 : 32'd0);
        chk("cap2_ovr", {31'd0, ovr}, CAP_ON ? 32'd1 : 32'd0);
        cap = 1'b0; en = 1'b0; ack = 1'b1;
        tick();
        chk("ack_cv", {31'd0, cv}, 32'd0);
        chk("ack_ovr", {31'd0, ovr}, 32'd0);
        cap = 1'b1;
        tick();
        chk("capack_cv", {31'd0, cv}, CAP_ON ? 32'd1 : 32'd0);
        chk("capack_cq", {24'd0, cq}, CAP_ON ? 32'd20 : 32'd0);
        chk("capack_ovr", {31'd0, ovr}, 32'd0);
        cap = 1'b0; ack = 1'b0;

        // Asynchronous reset mid-count
        nl = 1'b0; d = 8'h7E;
        tick();
        nl = 1'b1; cap = 1'b1;
        tick();
        chk("pre_rst_q", {24'd0, q}, 32'h7E);
        chk("pre_rst_cv", {31'd0, cv}, CAP_ON ? 32'd1 : 32'd0);
        cap = 1'b0; en = 1'b1;
        #2 nR = 1'b0;
        #1;
        chk("arst_q", {24'd0, q}, 32'd0);
        chk("arst_tcp", {31'd0, tcp}, 32'd0);
        chk("arst_cq", {24'd0, cq}, 32'd0);
        chk("arst_cv", {31'd0, cv}, 32'd0);
        chk("arst_ovr", {31'd0, ovr}, 32'd0);
        chk("arst_co", {31'd0, co}, 32'd0);
        #1 nR = 1'b1;
        tick();
        chk("resume_q", {24'd0, q}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cell_updown_counter
